// File: rtl/fifo_serial_tx_pkg.sv
// Shared types for the FIFO drain-side serial transmitter.
package fifo_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read-side handshake plus serial line outputs of the transmitter.
interface fifo_serial_tx_if #(parameter int width = 8) ();

  logic             enable;
  logic             empty;
  logic [width-1:0] rd_data;
  logic             read;
  logic             tx;
  logic             busy;

  // master: the transmitter, which initiates pops; slave: FIFO / board side
  modport master (input enable, empty, rd_data, output read, tx, busy);
  modport slave  (output enable, empty, rd_data, input read, tx, busy);

endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// Free-running per-bit cycle counter; done strobes on the last cycle of a bit.
module bit_timer #(
  parameter int clks_per_bit = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one word at a time from a show-ahead FIFO and shifts it out as a
// start/data(LSB first)/stop frame on a registered serial line.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int width        = 8,
  parameter int clks_per_bit = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_serial_tx_if.master bus
);

  localparam int IW = (width > 1) ? $clog2(width) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(width - 1);

  tx_state_t        state_q, state_d;
  logic [width-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             pop;
  logic             bit_done;
  logic             tmr_clear;

  // Pop only from IDLE, so read can never repeat on consecutive cycles
  assign pop = (state_q == IDLE) & bus.enable & ~bus.empty & ~reset;

  // Every state change restarts the bit period from zero
  assign tmr_clear = (state_d != state_q);

  bit_timer #(.clks_per_bit(clks_per_bit)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .done  (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = bus.rd_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Decode from next state so the registered line lines up with the state
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.read = pop;
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Drain-side consumer for the lab FIFO. Watches the FIFO's `empty` flag and pops one word at a time by pulsing `read`, capturing the head word from the FIFO's read-data bus. The word is sent on a single-wire UART-style line: start bit, data LSB first, stop bit. It sits between the FIFO storage/control pair and the board output pin, and is the reader counterpart to the FIFO's write-side producer.

## Interface
- `width`, 8: data word width in bits; must equal the FIFO word width.
- `clks_per_bit`, 4: clock cycles per serial bit, ≥ 2; kept small for simulation.

- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; returns block to idle immediately
- `enable`  in  1  permits starting a new frame; does not abort a frame in progress
- `empty`  in  1  FIFO empty flag
- `rd_data`  in  width  FIFO head word, show-ahead: valid whenever `empty`=0
- `read`  out  1  one-cycle pop strobe to FIFO
- `tx`  out  1  serial line, idles high
- `busy`  out  1  high from the cycle after the pop until the end of the stop bit

## Operation
- Reset values: `tx`=1, `read`=0, `busy`=0, state IDLE, bit timer 0, bit index 0, shift register 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `read` = `enable` & !`empty`, combinational, asserted only in IDLE.
  - On a clock edge with `read`=1: shift register ← `rd_data`; go to START.
  - `tx`=1.
- START: `tx`=0 for `clks_per_bit` cycles, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift[0] for `clks_per_bit` cycles, then shift right by one and increment the bit index.
  - After bit `width`-1, go to STOP.
- STOP: `tx`=1 for `clks_per_bit` cycles, then go to IDLE.
- Bit timer:
  - Counts 0..`clks_per_bit`-1, width $clog2(`clks_per_bit`).
  - Cleared on every state entry.
  - A "bit done" strobe fires when the count is `clks_per_bit`-1.
- Bit index width is $clog2(`width`); the comparison to `width`-1 is exact, with no wrap past it.
- `enable` deasserted mid-frame: the frame completes. The next pop is held until `enable`=1.
- `empty` rising mid-frame: ignored. The word is already captured.
- `rd_data` changing mid-frame: ignored.
- `reset` mid-frame:
  - `tx` returns to 1 asynchronously and the frame is truncated.
  - The popped word is lost and is not re-popped.

## Timing
- Pop to start bit: `read` is high in cycle N. `tx` falls in cycle N+1, and `busy` rises in cycle N+1.
- Frame length: (`width`+2)·`clks_per_bit` cycles. With defaults this is 40.
- Back-to-back frames:
  - STOP exits to IDLE, which always occupies at least one cycle with `tx`=1.
  - When the FIFO stays non-empty, consecutive start bits are (`width`+2)·`clks_per_bit`+1 cycles apart.
- `read` is never high in two consecutive cycles and never high while `busy`=1. The FIFO's pointer advance therefore sees exactly one pop per word.
- `busy` falls in the IDLE cycle following the last STOP cycle.

## Structure
- Package `fifo_serial_pkg` holds the state enum typedef `tx_state_t` {IDLE, START, DATA, STOP}.
- Sub-module `bit_timer`, parameterised by `clks_per_bit`:
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `done` strobe.
- Top level holds the FSM, shift register, bit index and output decode. `tx` is decoded from state and shift[0] and must be glitch-free, so it is registered.

## Test plan
- Reset then idle with `empty`=1 for 50 cycles → `tx`=1, `read`=0, `busy`=0 throughout.
- `empty`=0, `rd_data`=8'hA5, `enable`=1 → one `read` pulse. Then, over the following 40 cycles, `tx` carries the sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
- FIFO model preloaded with 8'h00, 8'hFF, 8'h3C → exactly 3 `read` pulses, 41 cycles apart, three correct frames, then idle.
- `enable` dropped 10 cycles into a frame of 8'h81 → the frame completes. No further `read` until `enable` is reasserted.
- `reset` asserted 15 cycles into a frame, mid-clock → `tx`=1 and `busy`=0 without waiting for an edge. After release, the next word starts a fresh frame and the lost word is not resent.
- `clks_per_bit`=2 and `width`=4, word 4'h9 → frame is 12 cycles long with bits 0,1,0,0,1,1.
